// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment display controller: bus offsets of the
// peripherals on this bus, the blank pattern and the active-low hex glyph table.
package seg7_pkg;

    // Offsets of the peripherals sharing this bus segment.
    typedef enum logic [11:0] {
        PERIPH_SEG7   = 12'h000,
        PERIPH_SWITCH = 12'h070,
        PERIPH_BUTTON = 12'h078
    } periph_offset_e;

    localparam int          NUM_DIGITS = 8;
    localparam logic [7:0]  SEG_BLANK  = 8'hFF;

    // Active-low glyphs, bit order {dp,g,f,e,d,c,b,a}; dp is 1 (off) in every entry.
    // Entry n sits at index n (the leftmost element is index 15).
    localparam logic [15:0][7:0] HEX_CODE = {
        8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,  // F..8
        8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0   // 7..0
    };

endpackage

// File: rtl/seg7_display_ctrl_hex_decode.sv
// Purely combinational nibble to active-low 7-segment glyph converter.
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [7:0] code
);

    // Table lookup; dp stays off because every table entry has bit 7 set.
    always_comb begin
        code = HEX_CODE[nibble];
    end

endmodule

// File: rtl/seg7_display_ctrl.sv
// Memory-mapped 8-digit common-anode 7-segment display controller.
// The CPU writes a 32-bit word at ADDR; the block scans it out as 8 hex digits,
// each digit lit for SCAN_CYCLES clocks, and returns the word on a registered read.
// Optional build macro SEG7_LEADZERO_BLANK_EN: blank leading-zero digits above digit 0.
module seg7_display_ctrl
    import seg7_pkg::*;
#(
    parameter logic [11:0]  ADDR        = 12'(PERIPH_SEG7),
    parameter int unsigned  SCAN_CYCLES = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] addr,
    input  logic        we,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic [7:0]  dig_en,
    output logic [7:0]  seg
);

    // A 1-cycle scan period still needs a 1-bit counter that simply stays at 0.
    localparam int             CNT_W    = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_CYCLES - 1);

    logic [31:0]      data_reg_q, data_reg_d;
    logic [31:0]      rdata_q,    rdata_d;
    logic [CNT_W-1:0] scan_cnt_q, scan_cnt_d;
    logic [2:0]       digit_idx_q, digit_idx_d;
    logic [7:0]       dig_en_q,   dig_en_d;
    logic [7:0]       seg_q,      seg_d;

    logic             sel;
    logic             tick;
    logic [3:0]       nibble;
    logic [7:0]       hex_code;
    logic             blank;

    // Bus decode: a matching write loads the data word, a matching read samples it.
    always_comb begin
        // NOTE: every signal assigned in always_comb gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        sel        = (addr == ADDR);
        data_reg_d = data_reg_q;
        rdata_d    = rdata_q;
        if (sel && we) begin
            data_reg_d = wdata;
        end
        if (sel && !we) begin
            rdata_d = data_reg_q;
        end
    end

    // Scan timing: free-running period counter; its wrap advances the digit index.
    always_comb begin
        tick        = (scan_cnt_q == CNT_LAST);
        scan_cnt_d  = tick ? '0 : scan_cnt_q + 1'b1;
        // 3-bit index wraps 7 -> 0 on its own.
        digit_idx_d = tick ? digit_idx_q + 3'd1 : digit_idx_q;
    end

    // Select the nibble of the digit currently being scanned.
    always_comb begin
        nibble = data_reg_q[4*digit_idx_q +: 4];
    end

    seg7_hex_decode u_hex_decode (
        .nibble (nibble),
        .code   (hex_code)
    );

    // Leading-zero blanking: digit i>0 goes dark when it and every higher nibble is 0.
    always_comb begin
`ifdef SEG7_LEADZERO_BLANK_EN
        blank = (digit_idx_q != 3'd0) && ((data_reg_q >> {digit_idx_q, 2'b00}) == 32'd0);
`else
        blank = 1'b0;
`endif
    end

    // Next display outputs: one-hot-zero anode enable plus decoded glyph.
    always_comb begin
        dig_en_d = ~(8'b1 << digit_idx_q);
        seg_d    = hex_code;
        if (blank) begin
            dig_en_d = SEG_BLANK;
            seg_d    = SEG_BLANK;
        end
    end

    // State and output registers; reset blanks the display and clears the data word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_reg_q  <= '0;
            rdata_q     <= '0;
            scan_cnt_q  <= '0;
            digit_idx_q <= '0;
            dig_en_q    <= SEG_BLANK;
            seg_q       <= SEG_BLANK;
        end else begin
            // NOTE: non-blocking assignments in clocked blocks so every register
            // samples pre-edge values regardless of statement order.
            data_reg_q  <= data_reg_d;
            rdata_q     <= rdata_d;
            scan_cnt_q  <= scan_cnt_d;
            digit_idx_q <= digit_idx_d;
            dig_en_q    <= dig_en_d;
            seg_q       <= seg_d;
        end
    end

    assign rdata  = rdata_q;
    assign dig_en = dig_en_q;
    assign seg    = seg_q;

endmodule

// File: tb/tb_seg7_display_ctrl.sv
// Scoreboard bench: a behavioural model predicts every output update of two
// instances (scan periods 4 and 1) and a monitor compares on the falling edge.
module tb_seg7_display_ctrl;

    localparam int unsigned SCAN0 = 4;
    localparam int unsigned SCAN1 = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [11:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata0, rdata1;
    logic [7:0]  dig_en0, seg0, dig_en1, seg1;

    always #5 clk = ~clk;

    seg7_display_ctrl #(.ADDR(12'h000), .SCAN_CYCLES(SCAN0)) u_dut0 (
        .clk(clk), .rst(rst), .addr(addr), .we(we), .wdata(wdata),
        .rdata(rdata0), .dig_en(dig_en0), .seg(seg0)
    );

    seg7_display_ctrl #(.ADDR(12'h000), .SCAN_CYCLES(SCAN1)) u_dut1 (
        .clk(clk), .rst(rst), .addr(addr), .we(we), .wdata(wdata),
        .rdata(rdata1), .dig_en(dig_en1), .seg(seg1)
    );

    typedef struct packed {
        logic [1:0][7:0] dig;
        logic [1:0][7:0] seg;
        logic [31:0]     rdata;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    logic [7:0] hex_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit leading_zero(int d, logic [31:0] v);
        return (d > 0) && ((v >> (4 * d)) == 32'd0);
    endfunction

    function automatic bit is_blank(int d, logic [31:0] v);
`ifdef SEG7_LEADZERO_BLANK_EN
        return leading_zero(d, v);
`else
        return (v === 32'hx) && (d < 0);
`endif
    endfunction

    function automatic logic [7:0] exp_dig_en(int d, logic [31:0] v);
        logic [7:0] one_hot;
        one_hot = 8'h01 << d;
        if (is_blank(d, v)) return 8'hFF;
        return ~one_hot;
    endfunction

    function automatic logic [7:0] exp_seg(int d, logic [31:0] v);
        logic [31:0] nib;
        nib = (v >> (4 * d)) & 32'hF;
        if (is_blank(d, v)) return 8'hFF;
        return hex_tab[nib[3:0]];
    endfunction

    logic [31:0] m_data  = 32'd0;
    logic [31:0] m_rdata = 32'd0;
    int unsigned m_edges = 0;
    exp_t        m_e;

    // Model: digit shown after edge n is floor(edges_before / scan) mod 8 of pre-edge data.
    always @(posedge clk) begin
        if (!rst) begin
            m_data  <= 32'd0;
            m_rdata <= 32'd0;
            m_edges <= 0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                int d;
                d = int'((m_edges / ((k == 0) ? SCAN0 : SCAN1)) % 8);
                m_e.dig[k] = exp_dig_en(d, m_data);
                m_e.seg[k] = exp_seg(d, m_data);
            end
            m_e.rdata = (addr == 12'h000 && !we) ? m_data : m_rdata;
            exp_q.push_back(m_e);
            m_rdata <= m_e.rdata;
            if (we && addr == 12'h000) m_data <= wdata;
            m_edges <= m_edges + 1;
        end
    end

    // ---------------- monitor ----------------
    exp_t mon_e;

    always @(negedge clk) begin
        if (!rst) begin
            exp_q.delete();
            check("reset dig_en0", {24'd0, dig_en0}, 32'hFF);
            check("reset seg0",    {24'd0, seg0},    32'hFF);
            check("reset rdata0",  rdata0,           32'd0);
            check("reset dig_en1", {24'd0, dig_en1}, 32'hFF);
        end else if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check("scan4 dig_en", {24'd0, dig_en0}, {24'd0, mon_e.dig[0]});
            check("scan4 seg",    {24'd0, seg0},    {24'd0, mon_e.seg[0]});
            check("scan1 dig_en", {24'd0, dig_en1}, {24'd0, mon_e.dig[1]});
            check("scan1 seg",    {24'd0, seg1},    {24'd0, mon_e.seg[1]});
            check("rdata0",       rdata0,           mon_e.rdata);
            check("rdata1",       rdata1,           mon_e.rdata);
        end
    end

    // ---------------- stimulus ----------------
    task automatic bus_write(input logic [11:0] a, input logic [31:0] d);
        @(negedge clk);
        addr  = a;
        we    = 1'b1;
        wdata = d;
        @(negedge clk);
        we    = 1'b0;
        addr  = 12'h100;
    endtask

    task automatic bus_read(input logic [11:0] a);
        @(negedge clk);
        addr = a;
        we   = 1'b0;
        @(negedge clk);
        addr = 12'h100;
    endtask

    initial begin
        bit found;
        addr  = 12'h100;
        we    = 1'b0;
        wdata = 32'd0;
        rst   = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;

        // Blank data: FE..7F, each held 4 cycles, all C0.
        repeat (40) @(negedge clk);

        bus_write(12'h000, 32'h89ABCDEF);
        repeat (40) @(negedge clk);

        // Other peripheral's offset must be ignored.
        bus_write(12'h078, 32'h12345678);
        repeat (40) @(negedge clk);

        bus_write(12'h000, 32'hDEADBEEF);
        bus_read(12'h000);
        check("readback deadbeef", rdata0, 32'hDEADBEEF);
        repeat (3) @(negedge clk);

        // Reset mid-scan at digit 5.
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if ((m_edges / SCAN0) % 8 == 5) begin
                found = 1'b1;
                break;
            end
        end
        check("reached digit 5", {31'd0, found}, 32'd1);
        #2 rst = 1'b0;
        #1;
        check("async reset dig_en", {24'd0, dig_en0}, 32'hFF);
        check("async reset seg",    {24'd0, seg0},    32'hFF);
        check("async reset rdata",  rdata0,           32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("first after release dig_en", {24'd0, dig_en0}, 32'hFE);
        check("first after release seg",    {24'd0, seg0},    32'hC0);
        repeat (40) @(negedge clk);

        // Leading-zero cases (blank only when the optional feature is built in).
        bus_write(12'h000, 32'h00001234);
        repeat (40) @(negedge clk);
        bus_write(12'h000, 32'h00000000);
        repeat (40) @(negedge clk);

        // Randomised bus traffic, including matching reads/writes and foreign offsets.
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            case ($urandom_range(0, 3))
                0, 1:    addr = 12'h000;
                2:       addr = ($urandom_range(0, 1) == 0) ? 12'h070 : 12'h078;
                default: addr = 12'($urandom);
            endcase
            we    = ($urandom_range(0, 2) == 0);
            wdata = ($urandom_range(0, 3) == 0) ? ($urandom >> ($urandom_range(0, 7) * 4)) : $urandom;
        end
        @(negedge clk);
        addr = 12'h100;
        we   = 1'b0;
        repeat (40) @(negedge clk);

        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
